// File: rtl/dpram_stream_reader.sv
// rtl/dpram_stream_reader.sv - burst reader for a 1-cycle-latency RAM, delivering words as a valid/ready stream
// Optional abort input when DPRAM_STREAM_READER_ABORT_EN is defined.
module dpram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DPRAM_STREAM_READER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] RdAddress,
  input  logic [DATA_WIDTH-1:0] Q,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rd_address_q, rd_address_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  tag1_q, tag1_d, tag1_last_q, tag1_last_d;
  logic                  tag2_q, tag2_d, tag2_last_q, tag2_last_d;
  logic                  arm_q, arm_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW:0]           occ;
  logic                  abort_req, push, pop, issue;

`ifdef DPRAM_STREAM_READER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign m_last    = m_valid & mem_q[rd_ptr_q][DATA_WIDTH];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign RdAddress = rd_address_q;

  assign pop  = m_valid & m_ready;
  assign push = tag2_q;
  // Credit counts words already buffered plus reads still in the RAM pipeline.
  assign occ  = {1'b0, count_q} + (CW+1)'(tag1_q) + (CW+1)'(tag2_q) - (CW+1)'(pop);
  assign issue = (state_q == ISSUE) && (rem_q != '0) && (occ < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    rd_address_d = rd_address_q;
    tag1_d       = 1'b0;
    tag1_last_d  = 1'b0;
    tag2_d       = tag1_q;
    tag2_last_d  = tag1_last_q;
    arm_d        = (state_q == FLUSH);
    done_d       = 1'b0;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);

    case (state_q)
      IDLE: begin
        if (start && !abort_req) begin
          addr_d  = base_addr;
          rem_d   = length;
          state_d = (length == '0) ? FLUSH : ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          rd_address_d = addr_q;
          addr_d       = addr_q + 1'b1;
          rem_d        = rem_q - 1'b1;
          tag1_d       = 1'b1;
          tag1_last_d  = (rem_q == (ADDR_WIDTH+1)'(1));
          if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // arm_q delays completion one cycle so an empty burst still spans two edges.
        if (arm_q && !tag1_q && !tag2_q && (count_q == '0)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {tag2_last_q, Q};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (abort_req && (state_q != IDLE)) begin
      state_d  = IDLE;
      rem_d    = '0;
      tag1_d   = 1'b0;
      tag2_d   = 1'b0;
      arm_d    = 1'b0;
      done_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      rd_address_q <= '0;
      tag1_q       <= 1'b0;
      tag1_last_q  <= 1'b0;
      tag2_q       <= 1'b0;
      tag2_last_q  <= 1'b0;
      arm_q        <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      rd_address_q <= rd_address_d;
      tag1_q       <= tag1_d;
      tag1_last_q  <= tag1_last_d;
      tag2_q       <= tag2_d;
      tag2_last_q  <= tag2_last_d;
      arm_q        <= arm_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb/tb_dpram_stream_reader.sv - scoreboard bench for dpram_stream_reader with a behavioural RAM
module tb_dpram_stream_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] base_addr = 8'h00;
  logic [8:0] length = 9'd0;
  logic [7:0] rd_address, q, m_data;
  logic       m_valid, m_last, busy, done;
`ifdef DPRAM_STREAM_READER_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [7:0] mem [256];
  logic [8:0] exp_q [$];
  logic [7:0] exp_addr_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         beats_seen = 0;
  int         ready_mode = 0;
  bit         check_addr = 1'b0;
  bit         hold_exempt = 1'b0;

  dpram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DPRAM_STREAM_READER_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .RdAddress (rd_address),
    .Q         (q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) q <= mem[rd_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic [7:0] b, input int l);
    for (int i = 0; i < l; i++) begin
      logic [7:0] a;
      a = b + i[7:0];
      exp_q.push_back({(i == l - 1), mem[a]});
    end
  endtask

  task automatic start_burst(input logic [7:0] b, input logic [8:0] l);
    @(negedge clk);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdaddr"}, rd_address, 0);
    check({tag, "_valid"},  m_valid, 0);
    check({tag, "_data"},   m_data, 0);
    check({tag, "_last"},   m_last, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
  endtask

  // m_ready driver: 0 = always 1, 1 = pattern 1,0,0,1,0, 2 = always 0, 3 = driven by the test
  initial begin
    int idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: begin m_ready = 1'b1; idx = 0; end
        1: begin m_ready = ((idx % 5) == 0) || ((idx % 5) == 3); idx++; end
        2: m_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Monitor: scoreboard pop on transfer, stall stability, issued address order
  initial begin
    bit         stall_prev;
    logic [7:0] data_prev, addr_prev;
    logic       last_prev;
    logic [8:0] e;
    logic [7:0] ea;
    stall_prev = 1'b0;
    data_prev  = 8'h00;
    last_prev  = 1'b0;
    addr_prev  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && !hold_exempt) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, data_prev);
          check("hold_last", m_last, last_prev);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_data, e[7:0]);
            check("beat_last", m_last, e[8]);
          end
          beats_seen++;
        end
        stall_prev = m_valid && !m_ready;
        data_prev  = m_data;
        last_prev  = m_last;
        if (check_addr && rd_address != addr_prev) begin
          if (exp_addr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_addr: got 0x%0h, required no address", rd_address);
          end else begin
            ea = exp_addr_q.pop_front();
            check("rd_address", rd_address, ea);
          end
        end
        addr_prev = rd_address;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Basic burst: latency, back-to-back beats, single done pulse
    push_burst(8'h10, 5);
    start_burst(8'h10, 9'd5);
    @(posedge clk); #1;
    check("lat_rdaddr", rd_address, 8'h10);
    check("lat_valid_t1", m_valid, 0);
    @(posedge clk); #1;
    check("lat_valid_t2", m_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("burst_valid", m_valid, 1);
    end
    @(posedge clk); #1;
    check("after_last_valid", m_valid, 0);
    check("done_early", done, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    @(posedge clk); #1;
    check("done_single", done, 0);
    check("basic_drained", exp_q.size(), 0);

    // Wrap-around addresses
    exp_addr_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check_addr = 1'b1;
    push_burst(8'hFE, 4);
    start_burst(8'hFE, 9'd4);
    wait_done(40, "wrap_done");
    check_addr = 1'b0;
    check("wrap_addr_drained", exp_addr_q.size(), 0);
    check("wrap_drained", exp_q.size(), 0);

    // Backpressure with an ignored start mid-burst
    ready_mode = 1;
    push_burst(8'h30, 8);
    start_burst(8'h30, 9'd8);
    repeat (3) @(posedge clk);
    #1 check("bp_busy_mid", busy, 1);
    @(negedge clk);
    base_addr = 8'h40;
    length    = 9'd3;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(80, "bp_done");
    ready_mode = 0;
    check("bp_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("bp_idle_after", busy, 0);

    // Zero-length burst
    start_burst(8'h00, 9'd0);
    check("zero_busy", busy, 1);
    @(posedge clk); #1;
    check("zero_done_t1", done, 0);
    check("zero_valid_t1", m_valid, 0);
    @(posedge clk); #1;
    check("zero_done_t2", done, 1);
    check("zero_valid_t2", m_valid, 0);

    // Full-range burst
    push_burst(8'h80, 256);
    start_burst(8'h80, 9'd256);
    wait_done(400, "full_done");
    check("full_drained", exp_q.size(), 0);

    // Reset mid-burst
    push_burst(8'h50, 8);
    beats_seen = 0;
    start_burst(8'h50, 9'd8);
    begin
      int k;
      k = 0;
      while (beats_seen < 3 && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    check("rst_beats_reached", (beats_seen >= 3), 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    check_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", m_valid, 0);
      check("post_rst_done", done, 0);
    end

`ifdef DPRAM_STREAM_READER_ABORT_EN
    // Abort after two accepted beats while stalled
    ready_mode = 2;
    push_burst(8'h60, 6);
    start_burst(8'h60, 9'd6);
    begin
      int k;
      k = 0;
      while (!m_valid && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
    end
    ready_mode = 3;
    m_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    #1;
    hold_exempt = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_two_beats", exp_q.size(), 4);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
      check("abort_no_valid", m_valid, 0);
    end
    hold_exempt = 1'b0;
    ready_mode = 0;
    push_burst(8'h20, 3);
    start_burst(8'h20, 9'd3);
    wait_done(40, "abort_next_done");
    check("abort_next_drained", exp_q.size(), 0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Read-side controller for the team's synchronous dual-port RAM, which has a registered read port with 1-cycle latency.
- On a start command it issues a burst of sequential read addresses and absorbs the RAM read latency.
- It delivers the words as a valid/ready stream with last-beat marking and full backpressure support.
- It sits between the line/feature buffers and downstream pipeline stages that consume buffered data.

Parameters:
- DATA_WIDTH, 8, width of RAM words and stream data.
- ADDR_WIDTH, 8, RAM address width; burst addresses wrap modulo 2^ADDR_WIDTH.
- FIFO_DEPTH, 4, internal output buffer entries; must be ≥3.

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle burst request; ignored while busy=1.
- base_addr  input  ADDR_WIDTH  first address of the burst, sampled with start.
- length  input  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH, sampled with start.
- RdAddress  output  ADDR_WIDTH  read address driven to the RAM read port.
- Q  input  DATA_WIDTH  RAM read data, valid the cycle after RdAddress is registered.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  marks the final beat of the burst; qualified by m_valid.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge) clears: RdAddress=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. It also empties the FIFO, clears the issue/in-flight tags, and sets state=IDLE.
- Reset mid-burst aborts the burst. No done pulse is produced, and no stale Q word is pushed after reset deasserts.
- State machine:
  - IDLE: on start=1, latch remaining=length and addr=base_addr, set busy=1. Go to ISSUE, or to FLUSH if length=0.
  - ISSUE: a read is issued on a cycle iff remaining>0 and (fifo_count + in_flight − pop_this_cycle) < FIFO_DEPTH. On issue: RdAddress<=addr, addr<=addr+1 (wraps from 2^ADDR_WIDTH−1 to 0), remaining<=remaining−1. When the last read issues, go to FLUSH.
  - FLUSH: wait until in_flight=0 and the FIFO is empty with the last beat accepted. Then done=1 for one cycle, busy=0, go to IDLE.
  - length=0: done pulses 2 cycles after the start edge. No beats and no reads are issued.
- Read pipeline:
  - A 2-stage valid tag follows each issued address: stage 1 marks that RdAddress was registered; stage 2 marks that Q is now valid.
  - Q is pushed into the FIFO on the edge where stage 2 is set.
  - The FIFO never overflows; the credit rule above guarantees this.
- Latency: start sampled at edge T0 puts the first RdAddress out at T1 and m_valid=1 after T3. That is 3 cycles from the start edge.
- Throughput: with m_ready held high, exactly one beat per cycle after the first beat, with no bubbles.
- Stream rules:
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
  - A beat transfers on m_valid & m_ready.
  - m_valid never drops without a transfer.
  - m_last=1 only on the beat numbered length.
- RdAddress holds its last value when no read issues. Reads with an invalid tag are discarded.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- start while busy=1 is ignored; latched values are unchanged.
- done and a new start in the same cycle: the start is accepted, because busy is already 0 in that cycle as seen from IDLE.

Optional Feature:
- Macro: DPRAM_STREAM_READER_ABORT_EN.
- With the macro defined, an extra input abort (1 bit) exists. abort=1 at a clock edge while busy:
  - clears the FIFO, the in-flight tags and remaining;
  - drops m_valid next cycle;
  - returns to IDLE with busy=0;
  - produces no done pulse and no m_last.
- abort while idle has no effect. abort takes priority over a simultaneous start.
- Without the macro, the port does not exist and a burst runs to completion or reset only.

Test Plan:
- Basic burst: RAM preloaded mem[i]=i; start with base=0x10, length=5, m_ready=1. Required:
  - beats 0x10..0x14 on 5 consecutive cycles;
  - m_valid first high 3 cycles after the start edge;
  - m_last only on 0x14;
  - done pulse one cycle after the last beat.
- Wrap-around: base=0xFE, length=4. Required: RdAddress sequence 0xFE,0xFF,0x00,0x01 and data mem[0xFE],mem[0xFF],mem[0],mem[1].
- Backpressure: length=8, m_ready toggling 1,0,0,1,0,…. Required:
  - all 8 beats in order, none lost or duplicated;
  - m_data held stable while stalled;
  - the FIFO count never exceeds 4.
- Edge lengths:
  - length=0: done 2 cycles after start, m_valid never high.
  - length=256: 256 beats, the last from address base−1.
- Start while busy and reset mid-burst:
  - start with base=0x40 mid-burst is ignored.
  - rst_n=0 after the 3rd beat: all outputs are 0 next cycle, and after reset releases no spurious m_valid or done appears.
- (DPRAM_STREAM_READER_ABORT_EN) abort after 2 of 6 beats with m_ready=0. Required: m_valid=0 next cycle, busy=0, no done pulse, and a new burst works correctly.
